// File: rtl/sort_stream_out_pkg.sv
// Shared constants for the sorter result streamer: FSM encoding, beat count and index width.
package sort_stream_out_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned BEATS = 4;
  localparam int unsigned IDX_W = 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

endpackage

// File: rtl/sort_stream_out_if.sv
// Valid/ready stream carrying one sorted element per beat, with an end-of-batch marker.
interface sort_stream_out_if #(
  parameter int unsigned N = 4
) ();

  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/sort_stream_out_signed_lt.sv
// Two's complement a < b from one subtractor: the sign of the difference, corrected on overflow.
module signed_lt #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  logic [N-1:0] diff;
  logic         ovf;

  always_comb begin
    diff = a - b;
    // Overflow only when the operand signs differ and the result sign disagrees with a.
    ovf  = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
    lt   = diff[N-1] ^ ovf;
  end

endmodule

// File: rtl/sort_stream_out.sv
// Captures a 4-entry sorter result on done and streams it out s0 first, checking
// that the batch is in non-increasing signed order.
module sort_stream_out
  import sort_stream_out_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic [N-1:0]     s0,
  input  logic [N-1:0]     s1,
  input  logic [N-1:0]     s2,
  input  logic [N-1:0]     s3,
  sort_stream_out_if.master out,
  output logic             busy,
  output logic             order_err,
  output logic [CNT_W-1:0] err_count,
  output logic             overrun
);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     buf_q [BEATS];
  logic [N-1:0]     buf_d [BEATS];
  logic             order_err_q;
  logic [CNT_W-1:0] err_count_q;
  logic             overrun_q;
  logic             hs, capture, drop;
  logic [BEATS-2:0] lt;

  always_comb begin
    hs      = (state_q == SEND) && out.out_ready;
    // A new batch is accepted when idle, or exactly on the final handshake.
    capture = done && ((state_q == IDLE) || (hs && (idx_q == LAST_IDX)));
    drop    = done && (state_q == SEND) && !capture;
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    if (capture) begin
      buf_d[0] = s0;
      buf_d[1] = s1;
      buf_d[2] = s2;
      buf_d[3] = s3;
      idx_d    = '0;
      state_d  = SEND;
    end else if (hs) begin
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Compare the incoming buffer contents so the verdict lands on the capture edge.
  for (genvar k = 0; k < BEATS - 1; k++) begin : g_cmp
    signed_lt #(.N(N)) u_lt (
      .a (buf_d[k]),
      .b (buf_d[k+1]),
      .lt(lt[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      order_err_q <= 1'b0;
      err_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        order_err_q <= |lt;
        if ((|lt) && (err_count_q != {CNT_W{1'b1}})) begin
          err_count_q <= err_count_q + 1'b1;
        end
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    out.out_valid = (state_q == SEND);
    out.out_data  = out.out_valid ? buf_q[idx_q] : '0;
    out.out_last  = out.out_valid && (idx_q == LAST_IDX);
    busy          = out.out_valid;
    order_err     = order_err_q;
    err_count     = err_count_q;
    overrun       = overrun_q;
  end

endmodule

// File: tb/tb_sort_stream_out.sv
// Directed bench for sort_stream_out: streaming, stalls, order check, back-to-back,
// overrun, mid-burst reset and counter saturation (second instance with CNT_W=2).
module tb_sort_stream_out;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic       rdy = 1'b1;
  logic [3:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;

  logic       busy, order_err, overrun;
  logic [7:0] err_count;
  logic       busy2, order_err2, overrun2;
  logic [1:0] err_count2;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  sort_stream_out_if #(.N(4)) bus ();
  sort_stream_out_if #(.N(4)) bus2 ();

  assign bus.out_ready  = rdy;
  assign bus2.out_ready = rdy;

  sort_stream_out #(.N(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .done     (done),
    .s0       (s0),
    .s1       (s1),
    .s2       (s2),
    .s3       (s3),
    .out      (bus),
    .busy     (busy),
    .order_err(order_err),
    .err_count(err_count),
    .overrun  (overrun)
  );

  sort_stream_out #(.N(4), .CNT_W(2)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .done     (done),
    .s0       (s0),
    .s1       (s1),
    .s2       (s2),
    .s3       (s3),
    .out      (bus2),
    .busy     (busy2),
    .order_err(order_err2),
    .err_count(err_count2),
    .overrun  (overrun2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [3:0] data, input logic last);
    chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " data"}, 32'(bus.out_data), 32'(data));
    chk({tag, " last"}, 32'(bus.out_last), 32'(last));
  endtask

  task automatic idle(input string tag);
    chk({tag, " valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    s0 = a; s1 = b; s2 = c; s3 = d;
    done = 1'b1;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("rst valid", 32'(bus.out_valid), 32'd0);
    chk("rst data", 32'(bus.out_data), 32'd0);
    chk("rst last", 32'(bus.out_last), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst order_err", 32'(order_err), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();
    idle("pre");

    // Basic batch 7,3,0,-2
    load(4'h7, 4'h3, 4'h0, 4'hE);
    tick();
    done = 1'b0;
    beat("b1.0", 4'h7, 1'b0);
    chk("b1 busy", 32'(busy), 32'd1);
    chk("b1 order_err", 32'(order_err), 32'd0);
    tick(); beat("b1.1", 4'h3, 1'b0);
    tick(); beat("b1.2", 4'h0, 1'b0);
    tick(); beat("b1.3", 4'hE, 1'b1);
    tick(); idle("b1 end");
    chk("b1 err_count", 32'(err_count), 32'd0);

    // Stall on the second beat for 3 cycles
    load(4'h7, 4'h3, 4'h0, 4'hE);
    tick();
    done = 1'b0;
    beat("st.0", 4'h7, 1'b0);
    tick();
    rdy = 1'b0;
    beat("st.1", 4'h3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("st hold", 4'h3, 1'b0);
    end
    rdy = 1'b1;
    tick(); beat("st.2", 4'h0, 1'b0);
    tick(); beat("st.3", 4'hE, 1'b1);
    tick(); idle("st end");

    // Order violation 3,7,7,-8 then back-to-back 7,-8,-8,-8
    load(4'h3, 4'h7, 4'h7, 4'h8);
    tick();
    done = 1'b0;
    chk("oe order_err", 32'(order_err), 32'd1);
    chk("oe err_count", 32'(err_count), 32'd1);
    beat("oe.0", 4'h3, 1'b0);
    tick(); beat("oe.1", 4'h7, 1'b0);
    tick(); beat("oe.2", 4'h7, 1'b0);
    tick(); beat("oe.3", 4'h8, 1'b1);
    load(4'h7, 4'h8, 4'h8, 4'h8);
    tick();
    done = 1'b0;
    beat("b2b.0", 4'h7, 1'b0);
    chk("b2b order_err", 32'(order_err), 32'd0);
    chk("b2b err_count", 32'(err_count), 32'd1);
    chk("b2b overrun", 32'(overrun), 32'd0);
    tick(); beat("b2b.1", 4'h8, 1'b0);
    tick(); beat("b2b.2", 4'h8, 1'b0);
    tick(); beat("b2b.3", 4'h8, 1'b1);
    tick(); idle("b2b end");
    chk("b2b order_err hold", 32'(order_err), 32'd0);

    // Overrun: done while stalled on beat 1
    load(4'h7, 4'h3, 4'h0, 4'hE);
    tick();
    done = 1'b0;
    beat("ov.0", 4'h7, 1'b0);
    tick();
    beat("ov.1", 4'h3, 1'b0);
    rdy = 1'b0;
    load(4'h1, 4'h1, 4'h1, 4'h1);
    tick();
    done = 1'b0;
    rdy = 1'b1;
    chk("ov flag", 32'(overrun), 32'd1);
    beat("ov hold", 4'h3, 1'b0);
    tick(); beat("ov.2", 4'h0, 1'b0);
    tick(); beat("ov.3", 4'hE, 1'b1);
    tick(); idle("ov end");
    chk("ov sticky", 32'(overrun), 32'd1);
    chk("ov err_count", 32'(err_count), 32'd1);

    // Reset during beat 2; coincident done is ignored
    load(4'h7, 4'h3, 4'h0, 4'hE);
    tick();
    done = 1'b0;
    tick();
    tick();
    beat("rm.2", 4'h0, 1'b0);
    rst = 1'b1;
    load(4'h6, 4'h6, 4'h6, 4'h6);
    tick();
    rst = 1'b0;
    done = 1'b0;
    idle("rm");
    chk("rm data", 32'(bus.out_data), 32'd0);
    chk("rm last", 32'(bus.out_last), 32'd0);
    chk("rm order_err", 32'(order_err), 32'd0);
    chk("rm err_count", 32'(err_count), 32'd0);
    chk("rm overrun", 32'(overrun), 32'd0);
    tick();
    idle("rm idle");
    load(4'h5, 4'h4, 4'h4, 4'hF);
    tick();
    done = 1'b0;
    beat("rf.0", 4'h5, 1'b0);
    tick(); beat("rf.1", 4'h4, 1'b0);
    tick(); beat("rf.2", 4'h4, 1'b0);
    tick(); beat("rf.3", 4'hF, 1'b1);
    chk("rf order_err", 32'(order_err), 32'd0);
    tick(); idle("rf end");

    // Five bad batches (0 < 1): wide counter reaches 5, 2-bit counter saturates at 3
    for (int b = 0; b < 5; b++) begin
      load(4'h0, 4'h1, 4'h0, 4'h0);
      tick();
      done = 1'b0;
      tick();
      tick();
      tick();
      tick();
    end
    chk("sat order_err", 32'(order_err), 32'd1);
    chk("sat wide", 32'(err_count), 32'd5);
    chk("sat narrow", 32'(err_count2), 32'd3);
    idle("sat end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/sort_stream_out.md
Name: sort_stream_out

Overview:
- Consumer for the 4-entry sorter's result bus.
- On the sorter's one-cycle done pulse, captures s0..s3 and streams them out one word per beat over a valid/ready interface, s0 first.
- Checks that the captured batch is in non-increasing signed order, i.e. the sorter's descending output convention.
- Reports per-batch order error, a saturating bad-batch count, and a sticky overrun flag.

Parameters:
- N, 4, data width of each element (two's complement); must match the sorter's N.
- CNT_W, 8, width of the bad-batch counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- done  in  1  one-cycle pulse from the sorter; s0..s3 are valid in that cycle.
- s0, s1, s2, s3  in  N each  sorted results.
- out_valid  out  1  out_data/out_last valid.
- out_ready  in  1  downstream accepts the beat when out_valid && out_ready.
- out_data  out  N  current element.
- out_last  out  1  high on the 4th beat of a batch.
- busy  out  1  high while a batch is being streamed.
- order_err  out  1  current/last batch violated s0>=s1>=s2>=s3 (signed).
- err_count  out  CNT_W  number of batches with order_err, saturating.
- overrun  out  1  sticky; a done arrived while busy and was not accepted.

Behaviour:
- Reset, synchronous, active-high, applied on any clk edge with rst=1 and valid mid-burst:
  - FSM returns to IDLE, idx=0.
  - out_valid=0, out_last=0, out_data=0, busy=0.
  - order_err=0, err_count=0, overrun=0; buffer contents are don't-care.
  - A done in the same cycle as rst is ignored.
- FSM has two states, IDLE and SEND.
- IDLE:
  - out_valid=0, busy=0.
  - On done=1: latch s0..s3 into buf[0..3], set idx=0, go to SEND.
  - In the same edge, order_err takes the registered result of the three signed compares; err_count increments if the result is set, saturating at all-ones.
- SEND:
  - out_valid=1, busy=1, out_data=buf[idx], out_last=(idx==3).
  - While out_ready=0, out_data and out_last hold stable; no change of any output.
  - On handshake with idx<3: idx<=idx+1.
  - On handshake with idx==3 and done=0: go to IDLE; out_valid is low the next cycle.
  - On handshake with idx==3 and done=1: recapture the new batch, idx<=0, stay in SEND. This gives back-to-back batches with no bubble, and order_err/err_count update for the new batch.
  - A done in any other SEND cycle is dropped and sets overrun<=1. overrun is cleared only by rst.
- Latency: done at cycle t gives the first beat with out_valid=1 at t+1. With out_ready held high, the four beats occupy t+1..t+4.
- Order check:
  - For each pair (k, k+1), violation = buf[k] <signed buf[k+1].
  - Computed as the N-bit difference a-b, with lt = sign(diff) XOR signed-overflow.
  - Equal values are not a violation.
  - Extremes (max positive vs most negative) must not misflag.
- order_err stays valid from the capture edge until the next capture; it is not cleared on return to IDLE.
- out_data is registered (driven from buf via registered idx); there is no combinational path from out_ready to out_valid.

Decomposition:
- Shared package:
  - state encoding constants IDLE=1'b0, SEND=1'b1;
  - beat count constant BEATS=4 and index width 2;
  - default N.
- One sub-module, signed_lt: parameter N, inputs a, b [N], output lt.
  - Implemented as subtract plus (sign XOR overflow).
  - Instantiated three times, on buf pairs (0,1), (1,2), (2,3).

Test Plan:
- N=4, out_ready=1, done with s=7,3,0,-2 (0111,0011,0000,1110):
  - beats 0111,0011,0000,1110 on cycles t+1..t+4, out_last only on the 4th;
  - order_err=0, err_count=0.
- Stall: same batch, out_ready low for 3 cycles on beat 2 → out_data=0011 held stable through the stall, then continues; total 4 handshakes, busy drops after the 4th.
- Order error and overflow extremes:
  - s=3,7,7,-8 → order_err=1, err_count=1;
  - next s=7,-8,-8,-8 → order_err=0 (no overflow misflag), err_count stays 1.
- Back-to-back: second done coincident with the 4th handshake → next cycle out_data=new s0, out_valid stays 1, overrun=0.
- Overrun: done asserted during beat 1 with out_ready=0 → overrun=1, buffer/output unchanged, original 4 beats complete.
- Reset mid-burst: rst during beat 2 → next cycle all outputs zero, state IDLE; a subsequent done streams a fresh batch normally.
- Saturation with CNT_W=2: 5 bad batches → err_count=3.
